// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver: frame FSM states, register map
// and STATUS bit positions, and the frame parity helper.
package ps2_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ps2_state_e;

    localparam logic ADDR_DATA   = 1'b0;
    localparam logic ADDR_STATUS = 1'b1;

    localparam int STAT_OVF_BIT   = 0;
    localparam int STAT_PAR_BIT   = 1;
    localparam int STAT_FRM_BIT   = 2;
    localparam int STAT_CNT_LSB   = 8;
    localparam int STAT_CNT_W     = 4;
    localparam int STAT_IRQEN_BIT = 16;

    localparam int DATA_BITS  = 8;
    localparam int PARITY_IDX = 8;
    localparam int STOP_IDX   = 9;

    // Odd parity holds when data plus parity carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous byte FIFO with simultaneous push/pop support; a push while full
// is honoured only when a pop frees a slot in the same cycle.
module ps2_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_pop_s;
    logic          do_push_s;

    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == (AW + 1)'(DEPTH));
    assign empty = (count_r == {(AW + 1){1'b0}});

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; power-of-2 pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_avalon.sv
// PS/2 device-to-host receiver: conditions the raw pins, decodes 11-bit frames,
// buffers bytes in a FIFO and exposes them through a two-register Avalon-MM slave.
module ps2_rx_avalon
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic        address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int FW  = $clog2(FILTER_LEN + 1);
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic           clk_meta_r;
    logic           clk_sync_r;
    logic           dat_meta_r;
    logic           dat_sync_r;
    logic [FW-1:0]  filt_cnt_r;
    logic           clk_filt_r;
    logic           clk_filt_d_r;
    logic           fall_s;

    ps2_state_e     state_r;
    logic [3:0]     bitcnt_r;
    logic [7:0]     shift_r;
    logic           parity_r;
    logic [WDW-1:0] wdog_r;
    logic           push_r;
    logic [7:0]     push_data_r;
    logic           frame_set_r;
    logic           parity_set_r;

    logic [7:0]     fifo_head_s;
    logic [CW-1:0]  fifo_count_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic           pop_s;
    logic           ovf_set_s;

    logic [2:0]     flags_r;
    logic [2:0]     flag_set_s;
    logic [2:0]     flag_clr_s;
    logic           irq_en_r;
    logic           irq_r;
    logic [31:0]    readdata_r;
    logic [31:0]    status_s;
    logic           status_wr_s;
    logic           unused_wd_s;

    assign fall_s = clk_filt_d_r & ~clk_filt_r;

    // Two-flop synchronizers; idle PS/2 lines sit high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_r <= 1'b1;
            clk_sync_r <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_sync_r <= 1'b1;
        end else begin
            clk_meta_r <= ps2_clk;
            clk_sync_r <= clk_meta_r;
            dat_meta_r <= ps2_dat;
            dat_sync_r <= dat_meta_r;
        end
    end

    // Clock deglitch: the filtered level follows only a sustained change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_cnt_r   <= {FW{1'b0}};
            clk_filt_r   <= 1'b1;
            clk_filt_d_r <= 1'b1;
        end else begin
            clk_filt_d_r <= clk_filt_r;
            if (clk_sync_r == clk_filt_r) begin
                filt_cnt_r <= {FW{1'b0}};
            end else if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
                filt_cnt_r <= {FW{1'b0}};
                clk_filt_r <= clk_sync_r;
            end else begin
                filt_cnt_r <= filt_cnt_r + {{(FW - 1){1'b0}}, 1'b1};
            end
        end
    end

    // Frame FSM with inter-bit watchdog; results are issued as 1-cycle pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            bitcnt_r     <= 4'd0;
            shift_r      <= 8'd0;
            parity_r     <= 1'b0;
            wdog_r       <= {WDW{1'b0}};
            push_r       <= 1'b0;
            push_data_r  <= 8'd0;
            frame_set_r  <= 1'b0;
            parity_set_r <= 1'b0;
        end else begin
            push_r       <= 1'b0;
            frame_set_r  <= 1'b0;
            parity_set_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    wdog_r <= {WDW{1'b0}};
                    if (fall_s && !dat_sync_r) begin
                        state_r  <= ST_SHIFT;
                        bitcnt_r <= 4'd0;
                    end
                end
                ST_SHIFT: begin
                    if (fall_s) begin
                        wdog_r   <= {WDW{1'b0}};
                        bitcnt_r <= bitcnt_r + 4'd1;
                        if (bitcnt_r < 4'(DATA_BITS)) begin
                            shift_r <= {dat_sync_r, shift_r[7:1]};
                        end else if (bitcnt_r == 4'(PARITY_IDX)) begin
                            parity_r <= dat_sync_r;
                        end else begin
                            state_r <= ST_IDLE;
                            if (!dat_sync_r) begin
                                frame_set_r <= 1'b1;
                            end else if (!odd_parity_ok(shift_r, parity_r)) begin
                                parity_set_r <= 1'b1;
                            end else begin
                                push_r      <= 1'b1;
                                push_data_r <= shift_r;
                            end
                        end
                    end else if (wdog_r == WDW'(TIMEOUT_CYC - 1)) begin
                        frame_set_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        wdog_r <= wdog_r + {{(WDW - 1){1'b0}}, 1'b1};
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign pop_s     = chipselect & read & (address == ADDR_DATA) & ~fifo_empty_s;
    assign ovf_set_s = push_r & fifo_full_s & ~pop_s;

    ps2_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (push_r),
        .din   (push_data_r),
        .pop   (pop_s),
        .head  (fifo_head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign status_wr_s = chipselect & write & (address == ADDR_STATUS);
    assign unused_wd_s = ^{writedata[31:17], writedata[15:3]};

    // Sticky flag set/clear vectors and the STATUS word image.
    always_comb begin
        flag_set_s               = 3'b000;
        flag_set_s[STAT_OVF_BIT] = ovf_set_s;
        flag_set_s[STAT_PAR_BIT] = parity_set_r;
        flag_set_s[STAT_FRM_BIT] = frame_set_r;
        if (status_wr_s) begin
            flag_clr_s = writedata[2:0];
        end else begin
            flag_clr_s = 3'b000;
        end
        status_s                                 = 32'd0;
        status_s[STAT_IRQEN_BIT]                 = irq_en_r;
        status_s[STAT_CNT_LSB +: STAT_CNT_W]     = STAT_CNT_W'(fifo_count_s);
        status_s[STAT_FRM_BIT]                   = flags_r[STAT_FRM_BIT];
        status_s[STAT_PAR_BIT]                   = flags_r[STAT_PAR_BIT];
        status_s[STAT_OVF_BIT]                   = flags_r[STAT_OVF_BIT];
    end

    // Control/status registers; a set in the clear cycle keeps the flag high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_r  <= 3'b000;
            irq_en_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            flags_r <= (flags_r & ~flag_clr_s) | flag_set_s;
            if (status_wr_s) begin
                irq_en_r <= writedata[STAT_IRQEN_BIT];
            end
            irq_r <= irq_en_r & (fifo_count_s != {CW{1'b0}});
        end
    end

    // Avalon read data, latency 1, held between reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'd0;
        end else if (chipselect && read) begin
            case (address)
                ADDR_DATA: begin
                    if (fifo_empty_s) begin
                        readdata_r <= 32'd0;
                    end else begin
                        readdata_r <= {23'd0, 1'b1, fifo_head_s};
                    end
                end
                ADDR_STATUS: readdata_r <= status_s;
                default:     readdata_r <= 32'd0;
            endcase
        end
    end

    assign readdata = readdata_r;
    assign irq      = irq_r;

endmodule
